id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline register sitting directly downstream of the opcode decoder.
- Captures the decoder's control bundle plus ID-stage operands each cycle and presents them to EX one cycle later.
- Contains load-use hazard detection: on a hazard it asserts a stall to PC/IF-ID and inserts a bubble into EX.
- Honours a branch flush from EX and keeps a saturating stall-cycle counter for performance debug.

Parameters:
- DATA_W, 32, operand/immediate/PC width
- REG_W, 5, register-specifier width
- CNT_W, 16, stall counter width

Ports:
- Clk  in  1  rising-edge clock
- Rst_n  in  1  synchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_alu_op  in  2  0=add, 1=LUI, 2=funct decode, 3=nop
- id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_branch, id_alu_src, id_reg_dst  in  1 each  decoder controls
- id_rs_data, id_rt_data  in  DATA_W  register-file read data
- id_imm  in  DATA_W  sign/zero-extended immediate
- id_pc4  in  DATA_W  PC+4 of ID instruction
- id_rs, id_rt, id_rd  in  REG_W  register specifiers
- flush  in  1  branch taken in EX; kill ID instruction
- ex_valid  out  1  EX holds a real instruction
- ex_alu_op  out  2  registered control
- ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_branch, ex_alu_src, ex_reg_dst  out  1 each  registered controls
- ex_rs_data, ex_rt_data, ex_imm, ex_pc4  out  DATA_W  registered operands
- ex_rs, ex_rt, ex_rd  out  REG_W  registered specifiers
- stall  out  1  combinational; freeze PC and IF/ID this cycle
- stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (Rst_n=0 at a rising edge):
  - all ex_* data/specifiers = 0, all 1-bit controls = 0, ex_valid = 0;
  - ex_alu_op = 3 (nop);
  - stall_count = 0.
  - Reset mid-stall discards the pending instruction; stall follows its equation from the post-reset EX state (ex_valid=0, so stall=0).
- Bubble definition: ex_valid=0, ex_alu_op=3, all 1-bit controls 0. Data/specifier fields are don't-care; drive them to 0.
- Source-usage terms:
  - uses_rs = id_valid & (id_reg_write | id_mem_read | id_mem_write | id_branch), with id_alu_op != 1 (LUI ignores rs).
  - uses_rt = id_valid & (~id_alu_src | id_mem_write | id_branch).
- Hazard (combinational):
  - hazard = ex_valid & ex_mem_read & (ex_rt != 0) & ((uses_rs & ex_rt==id_rs) | (uses_rt & ex_rt==id_rt)).
  - stall = hazard & ~flush.
- Per rising edge, first match wins:
  - Rst_n=0: reset values.
  - flush=1: load bubble; stall_count unchanged.
  - hazard=1: load bubble; stall_count += 1, saturating at all-ones.
  - id_valid=0: load bubble.
  - Otherwise: capture every id_* field into its ex_* counterpart; ex_valid=1.
- Latency: exactly 1 cycle ID→EX. No combinational path from id_* data to ex_* outputs.
- A load-use hazard stalls exactly one cycle: after the bubble, the load is no longer in EX, so the held ID instruction issues next cycle (forwarding covers MEM→EX).
- Back-to-back loads each feeding the next: one stall per pair, never two consecutive stall cycles.
- flush and hazard in the same cycle: flush wins, stall=0, the ID instruction is discarded, stall_count is not incremented.
- Register 0 never causes a hazard.

Test Plan:
- Reset: hold Rst_n=0 for 2 cycles with random id_* → ex_valid=0, ex_alu_op=3, all controls 0, stall_count=0, stall=0.
- Pass-through: id_valid=1, alu_op=2, reg_write=1, reg_dst=1, rs_data=0x11, rt_data=0x22, rs=1, rt=2, rd=3 → next cycle ex_* match exactly, ex_valid=1, stall=0.
- Load-use: cycle N issue lw (mem_read=1, alu_src=1, rt=5); cycle N+1 ID holds R-type with rs=5 → stall=1 in N+1, EX is bubble at N+2, stall_count=1, R-type reaches EX at N+3.
- No false hazard: lw to rt=0 followed by use of r0; lw rt=5 followed by addi with rt=5 as destination only (alu_src=1, rs=4) → stall=0 throughout.
- Flush priority: hazard condition set up as in the load-use case, plus flush=1 in the same cycle → stall=0, EX gets bubble, stall_count unchanged.
- Saturation: CNT_W=4, force 20 load-use hazards → stall_count stops at 15.

Source files
------------

// File: rtl/id_ex_if.sv
// ID/EX boundary bundle: decoder controls and operands in, registered EX copy,
// stall request and stall counter out.
interface id_ex_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CNT_W  = 16
);
  logic              id_valid;
  logic [1:0]        id_alu_op;
  logic              id_reg_write;
  logic              id_mem_to_reg;
  logic              id_mem_read;
  logic              id_mem_write;
  logic              id_branch;
  logic              id_alu_src;
  logic              id_reg_dst;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic [DATA_W-1:0] id_pc4;
  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic [REG_W-1:0]  id_rd;
  logic              flush;

  logic              ex_valid;
  logic [1:0]        ex_alu_op;
  logic              ex_reg_write;
  logic              ex_mem_to_reg;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_branch;
  logic              ex_alu_src;
  logic              ex_reg_dst;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm;
  logic [DATA_W-1:0] ex_pc4;
  logic [REG_W-1:0]  ex_rs;
  logic [REG_W-1:0]  ex_rt;
  logic [REG_W-1:0]  ex_rd;
  logic              stall;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output id_valid, id_alu_op, id_reg_write, id_mem_to_reg, id_mem_read,
           id_mem_write, id_branch, id_alu_src, id_reg_dst, id_rs_data,
           id_rt_data, id_imm, id_pc4, id_rs, id_rt, id_rd, flush,
    input  ex_valid, ex_alu_op, ex_reg_write, ex_mem_to_reg, ex_mem_read,
           ex_mem_write, ex_branch, ex_alu_src, ex_reg_dst, ex_rs_data,
           ex_rt_data, ex_imm, ex_pc4, ex_rs, ex_rt, ex_rd, stall, stall_count
  );

  modport slave (
    input  id_valid, id_alu_op, id_reg_write, id_mem_to_reg, id_mem_read,
           id_mem_write, id_branch, id_alu_src, id_reg_dst, id_rs_data,
           id_rt_data, id_imm, id_pc4, id_rs, id_rt, id_rd, flush,
    output ex_valid, ex_alu_op, ex_reg_write, ex_mem_to_reg, ex_mem_read,
           ex_mem_write, ex_branch, ex_alu_src, ex_reg_dst, ex_rs_data,
           ex_rt_data, ex_imm, ex_pc4, ex_rs, ex_rt, ex_rd, stall, stall_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch flush and a
// saturating stall-cycle counter.
module id_ex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic    Clk,
  input  logic    Rst_n,
  id_ex_if.slave  bus
);
  localparam logic [1:0] ALU_LUI = 2'd1;
  localparam logic [1:0] ALU_NOP = 2'd3;

  logic              r_valid;
  logic [1:0]        r_alu_op;
  logic              r_reg_write;
  logic              r_mem_to_reg;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_branch;
  logic              r_alu_src;
  logic              r_reg_dst;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_pc4;
  logic [REG_W-1:0]  r_rs;
  logic [REG_W-1:0]  r_rt;
  logic [REG_W-1:0]  r_rd;
  logic [CNT_W-1:0]  r_stall_count;

  logic w_uses_rs;
  logic w_uses_rt;
  logic w_hazard;
  logic w_load;

  // Load in EX whose destination is read by the instruction sitting in ID
  always_comb begin
    w_uses_rs = bus.id_valid & (bus.id_alu_op != ALU_LUI) &
                (bus.id_reg_write | bus.id_mem_read | bus.id_mem_write | bus.id_branch);
    w_uses_rt = bus.id_valid & (~bus.id_alu_src | bus.id_mem_write | bus.id_branch);
    w_hazard  = r_valid & r_mem_read & (r_rt != '0) &
                ((w_uses_rs & (r_rt == bus.id_rs)) | (w_uses_rt & (r_rt == bus.id_rt)));
    w_load    = bus.id_valid & ~bus.flush & ~w_hazard;
  end

  // Reset, flush, hazard and empty ID all collapse to loading a bubble
  always_ff @(posedge Clk) begin
    if (!Rst_n || !w_load) begin
      r_valid      <= 1'b0;
      r_alu_op     <= ALU_NOP;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_branch     <= 1'b0;
      r_alu_src    <= 1'b0;
      r_reg_dst    <= 1'b0;
      r_rs_data    <= '0;
      r_rt_data    <= '0;
      r_imm        <= '0;
      r_pc4        <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_rd         <= '0;
    end else begin
      r_valid      <= 1'b1;
      r_alu_op     <= bus.id_alu_op;
      r_reg_write  <= bus.id_reg_write;
      r_mem_to_reg <= bus.id_mem_to_reg;
      r_mem_read   <= bus.id_mem_read;
      r_mem_write  <= bus.id_mem_write;
      r_branch     <= bus.id_branch;
      r_alu_src    <= bus.id_alu_src;
      r_reg_dst    <= bus.id_reg_dst;
      r_rs_data    <= bus.id_rs_data;
      r_rt_data    <= bus.id_rt_data;
      r_imm        <= bus.id_imm;
      r_pc4        <= bus.id_pc4;
      r_rs         <= bus.id_rs;
      r_rt         <= bus.id_rt;
      r_rd         <= bus.id_rd;
    end
  end

  // Flush outranks the hazard, so a flushed stall is never counted
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_stall_count <= '0;
    end else if (w_hazard && !bus.flush && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

  assign bus.ex_valid      = r_valid;
  assign bus.ex_alu_op     = r_alu_op;
  assign bus.ex_reg_write  = r_reg_write;
  assign bus.ex_mem_to_reg = r_mem_to_reg;
  assign bus.ex_mem_read   = r_mem_read;
  assign bus.ex_mem_write  = r_mem_write;
  assign bus.ex_branch     = r_branch;
  assign bus.ex_alu_src    = r_alu_src;
  assign bus.ex_reg_dst    = r_reg_dst;
  assign bus.ex_rs_data    = r_rs_data;
  assign bus.ex_rt_data    = r_rt_data;
  assign bus.ex_imm        = r_imm;
  assign bus.ex_pc4        = r_pc4;
  assign bus.ex_rs         = r_rs;
  assign bus.ex_rt         = r_rt;
  assign bus.ex_rd         = r_rd;
  assign bus.stall         = w_hazard & ~bus.flush;
  assign bus.stall_count   = r_stall_count;
endmodule
